// File: rtl/line_fill_if.sv
// Bus bundle for the line fill unit.
//   req_*            : fill request handshake from the cache controller
//   mem_*            : single-outstanding word read channel to main memory
//   crit_word*       : early forward of the missed (critical) word
//   fill_*           : one-cycle cache write of the assembled line
//   busy             : unit is not idle
// The slave modport is the unit's view; the master modport is the environment's view.
interface line_fill_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 8,
  parameter int unsigned TAG_W   = 20,
  parameter int unsigned INDEX_W = 7
);
  localparam int unsigned LINE_W = 1 + TAG_W + WORDS * DATA_W;

  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_read_addr_valid;
  logic                mem_read_ready;
  logic                mem_read_valid;
  logic [DATA_W-1:0]   mem_read_data;
  logic                crit_word_valid;
  logic [DATA_W-1:0]   crit_word;
  logic                fill_valid;
  logic [INDEX_W-1:0]  fill_index;
  logic [LINE_W-1:0]   fill_line;
  logic                busy;

  modport slave (
    input  req_valid, req_addr, mem_read_ready, mem_read_valid, mem_read_data,
    output req_ready, mem_addr, mem_read_addr_valid, crit_word_valid, crit_word,
           fill_valid, fill_index, fill_line, busy
  );

  modport master (
    output req_valid, req_addr, mem_read_ready, mem_read_valid, mem_read_data,
    input  req_ready, mem_addr, mem_read_addr_valid, crit_word_valid, crit_word,
           fill_valid, fill_index, fill_line, busy
  );
endinterface

// File: rtl/line_fill_unit.sv
// Cacheline refill engine. Fetches the WORDS words of one line critical-word-first with
// wrap-around, one outstanding memory read at a time, forwards the critical word one cycle
// after it arrives and presents the assembled {valid, tag, data} line for one cycle.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : line_fill_if.slave (request, memory read, critical word, fill write, busy)
module line_fill_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 8,
  parameter int unsigned TAG_W   = 20,
  parameter int unsigned INDEX_W = 7
) (
  input logic       clk,
  input logic       rst,
  line_fill_if.slave bus
);
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned BUF_W  = WORDS * DATA_W;
  localparam int unsigned LINE_W = 1 + TAG_W + BUF_W;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StWrite} state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [OFF_W-1:0]   crit_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  crit_word_q;
  logic               crit_word_valid_q;
  logic [LINE_W-1:0]  fill_line_q;
  logic [INDEX_W-1:0] fill_index_q;

  logic [OFF_W-1:0]   slot;
  logic [OFF_W-1:0]   next_off;
  logic               beat;
  logic               last_beat;
  logic               unused_req_addr;

  // Offsets wrap naturally in OFF_W bits, giving the critical-word-first order.
  assign slot      = crit_q + cnt_q;
  assign next_off  = slot + 1'b1;
  assign beat      = (state_q == StData) && bus.mem_read_valid;
  assign last_beat = (cnt_q == OFF_W'(WORDS - 1));

  assign unused_req_addr = ^bus.req_addr[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = StAddr;
      StAddr:  if (bus.mem_read_ready) state_d = StData;
      StData:  if (bus.mem_read_valid) state_d = last_beat ? StWrite : StAddr;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.req_ready           = 1'b0;
    bus.mem_read_addr_valid = 1'b0;
    bus.fill_valid          = 1'b0;
    bus.busy                = 1'b1;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      StAddr:  bus.mem_read_addr_valid = 1'b1;
      StData:  ;
      StWrite: bus.fill_valid = 1'b1;
      default: ;
    endcase
  end

  // Line buffer with the arriving word merged in, so the last word can be
  // folded into the fill register in the same cycle it lands.
  always_comb begin
    buf_d = buf_q;
    if (beat) buf_d[slot * DATA_W +: DATA_W] = bus.mem_read_data;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q             <= '0;
      index_q           <= '0;
      crit_q            <= '0;
      cnt_q             <= '0;
      buf_q             <= '0;
      mem_addr_q        <= '0;
      crit_word_q       <= '0;
      crit_word_valid_q <= 1'b0;
      fill_line_q       <= '0;
      fill_index_q      <= '0;
    end else begin
      buf_q             <= buf_d;
      crit_word_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            tag_q      <= bus.req_addr[ADDR_W-1 -: TAG_W];
            index_q    <= bus.req_addr[OFF_W+2 +: INDEX_W];
            crit_q     <= bus.req_addr[2 +: OFF_W];
            cnt_q      <= '0;
            // First address is the critical word itself.
            mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          end
        end
        StData: begin
          if (beat) begin
            if (cnt_q == '0) begin
              crit_word_q       <= bus.mem_read_data;
              crit_word_valid_q <= 1'b1;
            end
            if (last_beat) begin
              fill_line_q  <= {1'b1, tag_q, buf_d};
              fill_index_q <= index_q;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              mem_addr_q <= {tag_q, index_q, next_off, 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr        = mem_addr_q;
  assign bus.crit_word       = crit_word_q;
  assign bus.crit_word_valid = crit_word_valid_q;
  assign bus.fill_line       = fill_line_q;
  assign bus.fill_index      = fill_index_q;
endmodule

// File: doc/line_fill_unit.md
Name: line_fill_unit

Overview:
Miss-side refill engine between the cache controller and main memory. On a fill request it fetches the 8 words of one 256-bit cacheline with critical-word-first ordering and wrap-around, forwards the critical word early, assembles the line into the cache write format (valid + tag + data) and presents it to the cache for a one-cycle write. One fill is in flight at a time, with one outstanding memory read.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, word width
WORDS, 8, words per cacheline (power of 2)
TAG_W, 20, tag width = addr[31:12]
INDEX_W, 7, set index width = addr[11:5]

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
req_valid  in  1  fill request strobe from cache controller
req_ready  out  1  unit idle, can accept a request
req_addr  in  32  miss address; word offset = addr[4:2]
mem_addr  out  32  word address to memory, addr[1:0]=0
mem_read_addr_valid  out  1  read address valid
mem_read_ready  in  1  memory accepts address this cycle
mem_read_valid  in  1  read data valid, one cycle
mem_read_data  in  32  read data
crit_word_valid  out  1  one-cycle pulse: requested word arrived
crit_word  out  32  requested word
fill_valid  out  1  one-cycle cache write strobe
fill_index  out  7  set index for the write
fill_line  out  277  {1'b1, tag[19:0], data[255:0]}; word w at [32w+31:32w]
busy  out  1  high whenever state != IDLE

Behaviour:
- All state is updated on posedge clk. Reset applies when rst==0 at a clock edge.
- Reset forces state IDLE and clears the counter and line buffer. All outputs reset to 0, except req_ready=1.
- States:
  - IDLE: req_ready=1. When req_valid=1, latch tag, index and crit=req_addr[4:2], clear cnt, go to ADDR. req_valid in any other state is ignored.
  - ADDR: mem_read_addr_valid=1 and mem_addr={tag,index,(crit+cnt) mod WORDS,2'b00}. Hold both until mem_read_ready=1, then go to DATA.
  - DATA: wait for mem_read_valid. On valid, write mem_read_data into buffer slot (crit+cnt) mod WORDS.
    - If cnt==0, also drive crit_word=mem_read_data with crit_word_valid=1 in the following cycle (registered).
    - If cnt==WORDS-1, go to WRITE; otherwise cnt++ and go to ADDR.
  - WRITE: fill_valid=1 for exactly one cycle with the completed fill_line and fill_index, then go to IDLE. No back-pressure: the cache always accepts.
- Wrap-around: offset arithmetic is 3-bit modulo. crit=6 fetches words 6,7,0,1,2,3,4,5.
- Latency: request accepted at cycle 0 (edge).
  - With mem_read_ready=1 in ADDR and mem_read_valid one cycle after address acceptance, each word takes 2 cycles.
  - crit_word_valid is high in cycle 3; fill_valid is high in cycle 17; req_ready returns in cycle 18.
  - Memory wait states extend ADDR or DATA one cycle per stall cycle.
- mem_read_valid outside DATA (IDLE, ADDR, WRITE) is ignored and does not change the buffer or cnt.
- mem_read_ready outside ADDR is ignored.
- Reset mid-fill returns to IDLE with no fill_valid. Data arriving afterwards is discarded per the rule above.
- fill_line[276] is always 1 when fill_valid=1. fill_line and fill_index hold their last values outside WRITE; the consumer qualifies them with fill_valid only.
- mem_addr holds its last value outside ADDR.

Test Plan:
- Reset with rst=0 for 2 cycles -> req_ready=1, busy=0, fill_valid=0, crit_word_valid=0, mem_read_addr_valid=0.
- req_addr=0x0001_2340, zero-wait memory returning word k = 0xA000_0000+k -> mem_addr sequence 0x12340, 0x12344 … 0x1235C; crit_word=0xA000_0000 in cycle 3; fill_valid in cycle 17 with fill_index=0x1A, tag=0x00012, fill_line[31:0]=0xA000_0000, fill_line[255:224]=0xA000_0007, bit 276=1.
- req_addr=0x0000_0018 (crit=6) -> mem_addr order 0x18, 0x1C, 0x00, 0x04 … 0x14; crit_word is memory word 6; each word lands in its own slot.
- mem_read_ready low for 3 cycles on the 2nd address, and mem_read_valid delayed 4 cycles on the 5th word -> mem_addr stable during the stall; fill_valid delayed by exactly 7 cycles versus the zero-wait case; line content unchanged.
- Spurious mem_read_valid=1 with data 0xDEAD_BEEF in IDLE and in ADDR -> no buffer change; a new req_valid during DATA is ignored (req_ready=0).
- rst=0 asserted after word 4 of a fill -> IDLE next cycle, no fill_valid; a following complete fill produces the correct line with no stale words.
